unified_mem_arbiter: RTL

UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

---
 rtl/unified_mem_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/unified_mem_arbiter.sv
// Arbiter that shares one single-port memory between instruction fetch (IF) and data (D) requesters.
// One transaction outstanding at a time, with a data-burst limit so fetches are not starved, and a BUSY timeout.
module unified_mem_arbiter #(
    parameter int MAX_DATA_BURST = 4,
    parameter int TIMEOUT        = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_mem
);
    localparam int SW = (MAX_DATA_BURST < 1) ? 1 : $clog2(MAX_DATA_BURST + 1);
    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;
    typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_e;

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic          we_q, we_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic          if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic          bus_err_q, bus_err_d;
    logic [31:0]   if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic          if_elig, d_elig, grant_if, grant_d, done_ok, done_err;

    // Fetches are word aligned; the low address bits are dropped deliberately.
    logic unused_if_addr;
    assign unused_if_addr = ^if_addr[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            streak_q    <= '0;
            tmo_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            wstrb_q     <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            streak_q    <= streak_d;
            tmo_q       <= tmo_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            wstrb_q     <= wstrb_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            bus_err_q   <= bus_err_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    always_comb begin
        // A requester whose completion pulse is showing this cycle is still holding the old request.
        if_elig  = if_req & ~if_rvalid_q;
        d_elig   = d_req & ~d_rvalid_q;
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (state_q == IDLE) begin
            grant_if = if_elig & (~d_elig | (streak_q == SW'(MAX_DATA_BURST)));
            grant_d  = d_elig & ~grant_if;
        end
        tmo_inc  = tmo_q + TW'(1);
        done_ok  = (state_q == BUSY) & mem_ready;
        done_err = (state_q == BUSY) & ~mem_ready & (tmo_inc == TW'(TIMEOUT));

        state_d     = state_q;
        owner_d     = owner_q;
        streak_d    = streak_q;
        tmo_d       = tmo_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        wstrb_d     = wstrb_q;
        if_rvalid_d = (done_ok | done_err) & (owner_q == OWN_IF);
        d_rvalid_d  = (done_ok | done_err) & (owner_q == OWN_D);
        bus_err_d   = done_err;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_if) begin
                    state_d  = BUSY;
                    owner_d  = OWN_IF;
                    streak_d = '0;
                    tmo_d    = '0;
                    addr_d   = {if_addr[31:2], 2'b00};
                    wdata_d  = '0;
                    we_d     = 1'b0;
                    wstrb_d  = '0;
                end else if (grant_d) begin
                    state_d  = BUSY;
                    owner_d  = OWN_D;
                    if (streak_q != SW'(MAX_DATA_BURST))
                        streak_d = streak_q + SW'(1);
                    tmo_d    = '0;
                    addr_d   = d_addr;
                    wdata_d  = d_wdata;
                    we_d     = d_we;
                    wstrb_d  = d_we ? d_wstrb : 4'b0000;
                end
            end
            BUSY: begin
                if (done_ok || done_err)
                    state_d = IDLE;
                else
                    tmo_d = tmo_inc;
            end
            default: state_d = IDLE;
        endcase

        // mem_ready wins over a coinciding timeout because done_err requires ~mem_ready.
        if (done_ok || done_err) begin
            if (owner_q == OWN_IF)
                if_rdata_d = done_ok ? mem_rdata : 32'h0;
            else
                d_rdata_d = done_ok ? mem_rdata : 32'h0;
        end
    end

    always_comb begin
        mem_req   = (state_q == BUSY);
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_wstrb = wstrb_q;
        if_rvalid = if_rvalid_q;
        d_rvalid  = d_rvalid_q;
        bus_err   = bus_err_q;
        if_rdata  = if_rdata_q;
        d_rdata   = d_rdata_q;
        stall_if  = if_req & ~if_rvalid_q;
        stall_mem = d_req & ~d_rvalid_q;
    end
endmodule
